// File: rtl/dcp_upsizer_if.sv
// Decoupled valid/ready channel: master drives Vld/Pld, slave drives Rdy.
// A transfer happens on a rising clock edge where Vld and Rdy are both high.
interface Decoupled #(
    parameter int W = 8
);
    logic         Vld;
    logic         Rdy;
    logic [W-1:0] Pld;

    modport master (output Vld, output Pld, input Rdy);
    modport slave  (input Vld, input Pld, output Rdy);
endinterface

// File: rtl/dcp_upsizer.sv
// Width upsizer: packs RATIO narrow beats into one wide word, closing early on a last flag.
// Define DCP_UPSIZER_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module dcp_upsizer #(
    parameter int IN_DW   = 32,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    Decoupled.slave                iDcpIn,
    Decoupled.master               oDcpOut,
    output logic [RATIO-1:0]       oKeep,
    output logic                   oLast,
    input  logic                   iFlush,
    output logic [$clog2(RATIO):0] oLaneCnt
);

    localparam int OUT_DW = IN_DW * RATIO;
    localparam int CNT_W  = $clog2(RATIO) + 1;

    if (RATIO < 2 || RATIO > 16) begin : gBadRatio
        $error("dcp_upsizer: RATIO must be within 2..16");
    end
    if (TIMEOUT < 1) begin : gBadTimeout
        $error("dcp_upsizer: TIMEOUT must be at least 1");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [OUT_DW-1:0]   word_q,  word_d;
    logic [RATIO-1:0]    keep_q,  keep_d;
    logic                last_q,  last_d;
    logic [CNT_W-1:0]    laneCnt_q, laneCnt_d;

`ifdef DCP_UPSIZER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

    logic             inRdy;
    logic             outVld;
    logic             inFire;
    logic             outFire;
    logic             inLast;
    logic [IN_DW-1:0] inData;

    assign inData  = iDcpIn.Pld[IN_DW-1:0];
    assign inLast  = iDcpIn.Pld[IN_DW];

    // In HOLD the input may only advance when the held word leaves, so a new beat always lands in a fresh word.
    assign outVld  = (state_q == HOLD) && !iFlush;
    assign inRdy   = !iRst && !iFlush && ((state_q == ACCUM) || oDcpOut.Rdy);
    assign inFire  = iDcpIn.Vld && inRdy;
    assign outFire = outVld && oDcpOut.Rdy;

    assign iDcpIn.Rdy  = inRdy;
    assign oDcpOut.Vld = outVld;
    assign oDcpOut.Pld = word_q;
    assign oKeep       = keep_q;
    assign oLast       = last_q;
    assign oLaneCnt    = laneCnt_q;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        keep_d    = keep_q;
        last_d    = last_q;
        laneCnt_d = laneCnt_q;
`ifdef DCP_UPSIZER_TIMEOUT_EN
        idle_d    = idle_q;
`endif
        if (iFlush) begin
            state_d   = ACCUM;
            word_d    = '0;
            keep_d    = '0;
            last_d    = 1'b0;
            laneCnt_d = '0;
`ifdef DCP_UPSIZER_TIMEOUT_EN
            idle_d    = '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (inFire) begin
                        for (int k = 0; k < RATIO; k++) begin
                            if (laneCnt_q == CNT_W'(k)) begin
                                word_d[k*IN_DW +: IN_DW] = inData;
                                keep_d[k]                = 1'b1;
                            end
                        end
                        laneCnt_d = laneCnt_q + 1'b1;
                        last_d    = inLast;
                        if (inLast || (laneCnt_q == CNT_W'(RATIO - 1))) begin
                            state_d = HOLD;
                        end
`ifdef DCP_UPSIZER_TIMEOUT_EN
                        idle_d = '0;
                    end else if (laneCnt_q != '0) begin
                        if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                            state_d = HOLD;
                            last_d  = 1'b0;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (outFire) begin
                        state_d   = ACCUM;
                        word_d    = '0;
                        keep_d    = '0;
                        last_d    = 1'b0;
                        laneCnt_d = '0;
                        // A beat taken alongside the handshake starts the next word with no bubble.
                        if (inFire) begin
                            word_d[IN_DW-1:0] = inData;
                            keep_d[0]         = 1'b1;
                            laneCnt_d         = CNT_W'(1);
                            if (inLast) begin
                                state_d = HOLD;
                                last_d  = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= ACCUM;
            word_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            laneCnt_q <= '0;
`ifdef DCP_UPSIZER_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            laneCnt_q <= laneCnt_d;
`ifdef DCP_UPSIZER_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

endmodule

// File: tb/tb_dcp_upsizer.sv
// Self-checking bench for dcp_upsizer (IN_DW=32, RATIO=4, default build):
// directed cases followed by random traffic, compared against a frame-level word model.
module tb_dcp_upsizer;

    localparam int IN_DW  = 32;
    localparam int RATIO  = 4;
    localparam int OUT_DW = IN_DW * RATIO;

    typedef struct packed {
        logic [OUT_DW-1:0] pld;
        logic [RATIO-1:0]  keep;
        logic              last;
    } word_t;

    logic       iClk;
    logic       iRst;
    logic       iFlush;
    logic [RATIO-1:0] oKeep;
    logic       oLast;
    logic [2:0] oLaneCnt;

    Decoupled #(.W(IN_DW + 1)) dIn ();
    Decoupled #(.W(OUT_DW))    dOut ();

    dcp_upsizer #(.IN_DW(IN_DW), .RATIO(RATIO), .TIMEOUT(16)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iDcpIn   (dIn),
        .oDcpOut  (dOut),
        .oKeep    (oKeep),
        .oLast    (oLast),
        .iFlush   (iFlush),
        .oLaneCnt (oLaneCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int vecCnt = 0;
    int errCnt = 0;

    logic [IN_DW-1:0] partData[$];
    word_t            expQ[$];

    function automatic word_t makeWord(input bit lastBit);
        word_t w;
        w.pld  = '0;
        w.keep = '0;
        w.last = lastBit;
        for (int i = 0; i < partData.size(); i++) begin
            w.pld[i*IN_DW +: IN_DW] = partData[i];
            w.keep[i]               = 1'b1;
        end
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [OUT_DW-1:0] obs, input logic [OUT_DW-1:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle from a negedge, checks against the model, then advances the model across the posedge.
    task automatic applyStimulus(input bit vld, input logic [IN_DW-1:0] data, input bit last,
                                 input bit rdy, input bit flush);
        bit    expVld, expRdy, inFire, outFire;
        word_t w;
        dIn.Vld  = vld;
        dIn.Pld  = {last, data};
        dOut.Rdy = rdy;
        iFlush   = flush;
        #1;
        expVld = !flush && (expQ.size() != 0);
        expRdy = !flush && ((expQ.size() == 0) || rdy);
        checkOutput("inRdy", OUT_DW'(dIn.Rdy), OUT_DW'(expRdy));
        checkOutput("outVld", OUT_DW'(dOut.Vld), OUT_DW'(expVld));
        if (expVld) begin
            checkOutput("outPld", dOut.Pld, expQ[0].pld);
            checkOutput("outKeep", OUT_DW'(oKeep), OUT_DW'(expQ[0].keep));
            checkOutput("outLast", OUT_DW'(oLast), OUT_DW'(expQ[0].last));
        end
        if (expQ.size() == 0) begin
            checkOutput("laneCnt", OUT_DW'(oLaneCnt), OUT_DW'(partData.size()));
        end
        inFire  = vld && expRdy;
        outFire = expVld && rdy;
        @(posedge iClk);
        if (flush) begin
            partData.delete();
            expQ.delete();
        end else begin
            if (outFire) w = expQ.pop_front();
            if (inFire) begin
                partData.push_back(data);
                if (last || (partData.size() == RATIO)) begin
                    expQ.push_back(makeWord(last));
                    partData.delete();
                end
            end
        end
        @(negedge iClk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Vld"}, OUT_DW'(dOut.Vld), '0);
        checkOutput({tag, "Rdy"}, OUT_DW'(dIn.Rdy), '0);
        checkOutput({tag, "Pld"}, dOut.Pld, '0);
        checkOutput({tag, "Keep"}, OUT_DW'(oKeep), '0);
        checkOutput({tag, "Last"}, OUT_DW'(oLast), '0);
        checkOutput({tag, "LaneCnt"}, OUT_DW'(oLaneCnt), '0);
    endtask

    initial begin
        iRst     = 1'b1;
        iFlush   = 1'b0;
        dIn.Vld  = 1'b0;
        dIn.Pld  = '0;
        dOut.Rdy = 1'b0;
        #2;
        checkResetState("rst");
        @(negedge iClk);
        iRst = 1'b0;

        $display("[TB] four beats closed by last");
        applyStimulus(1, 32'h11, 0, 1, 0);
        applyStimulus(1, 32'h22, 0, 1, 0);
        applyStimulus(1, 32'h33, 0, 1, 0);
        applyStimulus(1, 32'h44, 1, 1, 0);
        dIn.Vld = 1'b0;
        #1;
        checkOutput("fullVld", OUT_DW'(dOut.Vld), OUT_DW'(1));
        checkOutput("fullPld", dOut.Pld, 128'h00000044_00000033_00000022_00000011);
        checkOutput("fullKeep", OUT_DW'(oKeep), OUT_DW'(4'b1111));
        checkOutput("fullLast", OUT_DW'(oLast), OUT_DW'(1));
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);

        $display("[TB] short frame of two beats");
        applyStimulus(1, 32'hA, 0, 1, 0);
        applyStimulus(1, 32'hB, 1, 1, 0);
        dIn.Vld = 1'b0;
        #1;
        checkOutput("shortPld", dOut.Pld, 128'h0000000B_0000000A);
        checkOutput("shortKeep", OUT_DW'(oKeep), OUT_DW'(4'b0011));
        checkOutput("shortLast", OUT_DW'(oLast), OUT_DW'(1));
        applyStimulus(0, 32'h0, 0, 1, 0);

        $display("[TB] eight back-to-back beats without last");
        for (int i = 0; i < 8; i++) applyStimulus(1, 32'h100 + i, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);

        $display("[TB] output stalled for five cycles");
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h200 + i, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, $urandom, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);

        $display("[TB] flush discards a partial word");
        applyStimulus(1, 32'h301, 0, 1, 0);
        applyStimulus(1, 32'h302, 0, 1, 0);
        applyStimulus(1, 32'h303, 0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h400 + i, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        $display("[TB] reset in the middle of a word");
        applyStimulus(0, 32'h0, 0, 1, 1);
        applyStimulus(1, 32'h501, 0, 1, 0);
        applyStimulus(1, 32'h502, 0, 1, 0);
        dIn.Vld = 1'b0;
        #2;
        iRst = 1'b1;
        #1;
        checkResetState("midRst");
        partData.delete();
        expQ.delete();
        @(negedge iClk);
        iRst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h600 + i, i == 3, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/dcp_upsizer.md
DCP_UPSIZER -- requirements
Module: dcp_upsizer

Interface
REQ-001 SHALL have parameter IN_DW, default 32: input beat data width.
REQ-002 SHALL have parameter RATIO, default 4: input beats per output word; legal values 2..16.
REQ-003 SHALL have derived parameter OUT_DW = IN_DW*RATIO; it SHALL NOT be overridden.
REQ-004 SHALL have parameter TIMEOUT, default 16: idle cycles before partial flush; used only under REQ-026.
REQ-005 SHALL have port iClk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port iRst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port iDcpIn, Decoupled.slave, Pld IN_DW+1: input beats; Pld[IN_DW] = last flag, Pld[IN_DW-1:0] = data.
REQ-008 SHALL have port oDcpOut, Decoupled.master, Pld OUT_DW: packed output words; beat k occupies Pld[k*IN_DW +: IN_DW].
REQ-009 SHALL have port oKeep, output, RATIO: per-lane valid mask, qualified by oDcpOut.Vld.
REQ-010 SHALL have port oLast, output, 1: output word closes a frame, qualified by oDcpOut.Vld.
REQ-011 SHALL have port iFlush, input, 1: synchronous discard of partial and held state.
REQ-012 SHALL have port oLaneCnt, output, $clog2(RATIO)+1: number of lanes currently filled in the accumulating word.

Function
REQ-013 SHALL implement two states: ACCUM (collecting beats, output invalid) and HOLD (word presented, oDcpOut.Vld=1).
REQ-014 In ACCUM, iDcpIn.Rdy SHALL be 1; each accepted beat SHALL be written to lane oLaneCnt, and oLaneCnt SHALL increment.
REQ-015 ACCUM->HOLD SHALL occur on the edge accepting a beat that fills lane RATIO-1 or carries last=1; oDcpOut.Vld SHALL rise the following cycle (1-cycle latency).
REQ-016 In HOLD, iDcpIn.Rdy SHALL equal oDcpOut.Rdy; oDcpOut.Pld, oKeep and oLast SHALL stay stable until the handshake completes.
REQ-017 On HOLD handshake with no input beat accepted, the state SHALL become ACCUM with oLaneCnt=0.
REQ-018 On HOLD handshake with an input beat accepted in the same cycle, that beat SHALL land in lane 0 of a new word; if it has last=1 (or RATIO... not applicable, RATIO>=2), state SHALL remain HOLD with the new 1-lane word, else ACCUM with oLaneCnt=1; no bubble.
REQ-019 oKeep SHALL have bit k set iff lane k was written; unwritten lanes of Pld SHALL be zero.
REQ-020 oLast SHALL be 1 iff the closing beat had last=1; a full word without last SHALL have oLast=0.
REQ-021 Sustained input with oDcpOut.Rdy=1 SHALL give throughput of one input beat per cycle.
REQ-022 iFlush=1 SHALL force iDcpIn.Rdy=0 and oDcpOut.Vld=0 that cycle, and next state SHALL be ACCUM, oLaneCnt=0, lanes zero; iFlush SHALL take priority over all handshakes.

Reset
REQ-023 While iRst=1, state SHALL be ACCUM, oLaneCnt=0, oDcpOut.Vld=0, oKeep=0, oLast=0, oDcpOut.Pld=0, asynchronously.
REQ-024 iDcpIn.Rdy SHALL be 0 while iRst=1 and become 1 the first cycle after deassertion.
REQ-025 Reset mid-word SHALL discard all partial and held data; no output word SHALL be produced for it.

Configuration
REQ-026 With macro DCP_UPSIZER_TIMEOUT_EN defined, an idle counter SHALL count cycles in ACCUM with oLaneCnt>0 and no accepted beat; reaching TIMEOUT SHALL transition to HOLD with the partial word, oLast=0; any accepted beat SHALL clear the counter.
REQ-027 Without DCP_UPSIZER_TIMEOUT_EN, no idle counter SHALL exist and partial words SHALL wait indefinitely for more beats, last, or iFlush.

Verification
REQ-028 IN_DW=32, RATIO=4, beats 0x11,0x22,0x33,0x44 (last on 4th), Rdy=1 -> one word Pld=0x00000044_00000033_00000022_00000011, oKeep=4'b1111, oLast=1, Vld 1 cycle after 4th beat.
REQ-029 Beats 0xA,0xB with last on 0xB -> Pld=0x..._0000000B_0000000A with upper lanes 0, oKeep=4'b0011, oLast=1.
REQ-030 8 back-to-back beats no last, oDcpOut.Rdy=1 -> two words, oKeep=4'b1111, oLast=0, iDcpIn.Rdy never deasserts.
REQ-031 HOLD with oDcpOut.Rdy=0 for 5 cycles -> iDcpIn.Rdy=0, Pld/oKeep/oLast unchanged for all 5 cycles.
REQ-032 2 beats accepted, then iFlush=1 for 1 cycle -> oLaneCnt=0, no output word; next 4 beats produce a clean word.
REQ-033 DCP_UPSIZER_TIMEOUT_EN, TIMEOUT=16, 3 beats then idle -> word with oKeep=4'b0111, oLast=0, Vld asserted 16 cycles after last accepted beat (+1 latency).
